// File: rtl/z16_writeback_unit.sv
// z16_writeback_unit: writeback merge of ALU results and buffered loads into
// the single register-file write port, with starvation guard and an optional
// pending-load scoreboard (enabled by defining Z16_WB_SCOREBOARD_EN).
module z16_writeback_unit #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned LDQ_DEPTH    = 2,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_alu_valid,
  input  logic [3:0]        i_alu_rd_addr,
  input  logic [DATA_W-1:0] i_alu_data,
  output logic              o_alu_stall,
  input  logic              i_ld_valid,
  output logic              o_ld_ready,
  input  logic [3:0]        i_ld_rd_addr,
  input  logic [DATA_W-1:0] i_ld_data,
  input  logic              i_ld_issue_valid,
  input  logic [3:0]        i_ld_issue_addr,
  output logic [15:0]       o_busy,
  output logic [3:0]        o_rd_addr,
  output logic              o_rd_we,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int unsigned PTR_W = (LDQ_DEPTH > 1) ? $clog2(LDQ_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  logic [3:0]        r_q_addr [LDQ_DEPTH];
  logic [DATA_W-1:0] r_q_data [LDQ_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [STV_W-1:0]  r_starve;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_alu_win;
  logic [3:0]        w_head_addr;
  logic [DATA_W-1:0] w_head_data;

  assign w_full      = (r_count == CNT_W'(LDQ_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_head_addr = r_q_addr[r_rd_ptr];
  assign w_head_data = r_q_data[r_rd_ptr];

  // Ready depends only on occupancy; held low while in reset
  assign o_ld_ready = !i_rst && !w_full;
  assign w_push     = i_ld_valid && o_ld_ready;

  // Arbitration: ALU first unless the waiting load has been starved too long
  always_comb begin
    w_alu_win   = 1'b0;
    w_pop       = 1'b0;
    o_alu_stall = 1'b0;
    if (!i_rst) begin
      w_alu_win   = i_alu_valid && (r_starve < STV_W'(STARVE_LIMIT));
      w_pop       = !w_alu_win && !w_empty;
      o_alu_stall = i_alu_valid && !w_alu_win;
    end
  end

  // Load FIFO payload storage (no reset needed, validity tracked by r_count)
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q_addr[r_wr_ptr] <= i_ld_rd_addr;
      r_q_data[r_wr_ptr] <= i_ld_data;
    end
  end

  // FIFO pointers, occupancy and starvation counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_starve <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
      if (w_pop || w_empty)
        r_starve <= '0;
      else if (w_alu_win && (r_starve < STV_W'(STARVE_LIMIT)))
        r_starve <= r_starve + STV_W'(1);
    end
  end

  // Registered write port; destination r0 is consumed but never enabled
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rd_addr <= '0;
      o_rd_we   <= 1'b0;
      o_rd_data <= '0;
    end else if (w_alu_win) begin
      o_rd_addr <= i_alu_rd_addr;
      o_rd_data <= i_alu_data;
      o_rd_we   <= (i_alu_rd_addr != 4'd0);
    end else if (w_pop) begin
      o_rd_addr <= w_head_addr;
      o_rd_data <= w_head_data;
      o_rd_we   <= (w_head_addr != 4'd0);
    end else begin
      o_rd_we   <= 1'b0;
    end
  end

`ifdef Z16_WB_SCOREBOARD_EN
  logic [15:0] r_busy;
  logic [15:0] w_set;
  logic [15:0] w_clr;

  // Set/clear masks; a new issue overrides a same-cycle clear
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (i_ld_issue_valid && (i_ld_issue_addr != 4'd0))
      w_set = 16'(1) << i_ld_issue_addr;
    if (w_pop)
      w_clr = 16'(1) << w_head_addr;
  end

  // Pending-load scoreboard; bit 0 is never set
  always_ff @(posedge i_clk) begin
    if (i_rst) r_busy <= '0;
    else       r_busy <= ((r_busy & ~w_clr) | w_set) & 16'hFFFE;
  end

  assign o_busy = r_busy;
`else
  logic w_unused_issue;
  assign w_unused_issue = ^{i_ld_issue_valid, i_ld_issue_addr};
  assign o_busy = '0;
`endif

endmodule

// File: tb/tb_z16_writeback_unit.sv
// Testbench for z16_writeback_unit: directed scenarios with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_z16_writeback_unit;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 2;
  localparam int LIMIT  = 3;
`ifdef Z16_WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              alu_valid;
  logic [3:0]        alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_stall;
  logic              ld_valid;
  logic              ld_ready;
  logic [3:0]        ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              iss_valid;
  logic [3:0]        iss_addr;
  logic [15:0]       busy;
  logic [3:0]        rd_addr;
  logic              rd_we;
  logic [DATA_W-1:0] rd_data;

  always #5 clk = ~clk;

  z16_writeback_unit #(.DATA_W(DATA_W), .LDQ_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_alu_valid(alu_valid), .i_alu_rd_addr(alu_addr), .i_alu_data(alu_data),
    .o_alu_stall(alu_stall),
    .i_ld_valid(ld_valid), .o_ld_ready(ld_ready),
    .i_ld_rd_addr(ld_addr), .i_ld_data(ld_data),
    .i_ld_issue_valid(iss_valid), .i_ld_issue_addr(iss_addr),
    .o_busy(busy), .o_rd_addr(rd_addr), .o_rd_we(rd_we), .o_rd_data(rd_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [19:0] mq[$];            // {addr, data}
  int          m_starve = 0;
  bit [15:0]   m_busy   = '0;
  logic        m_we     = 1'b0;
  logic [3:0]  m_addr   = '0;
  logic [15:0] m_data   = '0;
  logic        m_ready;
  logic        m_stall;
  logic        last_stall = 1'b0;
  logic        last_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the spec's arbitration rules over a plain queue
  task automatic model_cycle(input logic r, av, input logic [3:0] aa, input logic [15:0] ad,
                             input logic lv, input logic [3:0] la, input logic [15:0] ld,
                             input logic iv, input logic [3:0] ia);
    logic [19:0] e;
    bit push;
    if (r) begin
      mq.delete();
      m_starve = 0; m_busy = '0;
      m_we = 1'b0; m_addr = '0; m_data = '0;
      m_ready = 1'b0; m_stall = 1'b0;
      return;
    end
    m_ready = (mq.size() < DEPTH);
    push    = lv && m_ready;
    m_stall = 1'b0;
    m_we    = 1'b0;
    if (av && m_starve < LIMIT) begin
      m_addr = aa; m_data = ad; m_we = (aa != 0);
      m_starve = (mq.size() == 0) ? 0 : ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1);
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_addr = e[19:16]; m_data = e[15:0]; m_we = (e[19:16] != 0);
      m_stall = av;
      m_starve = 0;
      m_busy[e[19:16]] = 1'b0;
    end else begin
      m_starve = 0;
    end
    if (iv && ia != 0) m_busy[ia] = 1'b1;
    m_busy[0] = 1'b0;
    if (push) mq.push_back({la, ld});
  endtask

  // One clock: drive at negedge, check combinational outputs, then registered
  task automatic step(input logic r, av, input logic [3:0] aa, input logic [15:0] ad,
                      input logic lv, input logic [3:0] la, input logic [15:0] ld,
                      input logic iv, input logic [3:0] ia);
    @(negedge clk);
    rst = r; alu_valid = av; alu_addr = aa; alu_data = ad;
    ld_valid = lv; ld_addr = la; ld_data = ld; iss_valid = iv; iss_addr = ia;
    #1;
    model_cycle(r, av, aa, ad, lv, la, ld, iv, ia);
    chk("ld_ready", 32'(ld_ready), 32'(m_ready));
    chk("alu_stall", 32'(alu_stall), 32'(m_stall));
    last_stall = alu_stall;
    last_ready = ld_ready;
    @(posedge clk);
    #1;
    chk("rd_we", 32'(rd_we), 32'(m_we));
    chk("rd_addr", 32'(rd_addr), 32'(m_addr));
    chk("rd_data", 32'(rd_data), 32'(m_data));
    chk("busy", 32'(busy), SB ? 32'(m_busy) : 32'd0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0);
  endtask

  logic        h_av;
  logic [3:0]  h_aa;
  logic [15:0] h_ad;

  initial begin
    rst = 1'b1; alu_valid = 0; alu_addr = 0; alu_data = 0;
    ld_valid = 0; ld_addr = 0; ld_data = 0; iss_valid = 0; iss_addr = 0;

    // Reset state
    step(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0);
    step(1'b1, 1'b1, 4'd2, 16'h5555, 1'b1, 4'd2, 16'd1, 1'b1, 4'd2);
    chk("rst_ready_lit", 32'(last_ready), 32'd0);
    chk("rst_stall_lit", 32'(last_stall), 32'd0);
    chk("rst_we_lit", 32'(rd_we), 32'd0);
    chk("rst_busy_lit", 32'(busy), 32'd0);

    // ALU write
    step(1'b0, 1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0);
    chk("alu_we_lit", 32'(rd_we), 32'd1);
    chk("alu_addr_lit", 32'(rd_addr), 32'd3);
    chk("alu_data_lit", 32'(rd_data), 32'h1234);
    chk("alu_stall_lit", 32'(last_stall), 32'd0);

    // Single load with idle ALU
    step(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0);
    chk("ld_ready_lit0", 32'(last_ready), 32'd1);
    idle();
    chk("ld_ready_lit1", 32'(last_ready), 32'd1);
    chk("ld_we_lit", 32'(rd_we), 32'd1);
    chk("ld_addr_lit", 32'(rd_addr), 32'd5);
    chk("ld_data_lit", 32'(rd_data), 32'hBEEF);

    // Starvation: two loads pushed under continuous ALU traffic
    step(1'b0, 1'b1, 4'd1, 16'h0001, 1'b1, 4'd6, 16'hA006, 1'b0, 4'd0);
    step(1'b0, 1'b1, 4'd1, 16'h0002, 1'b1, 4'd9, 16'hA009, 1'b0, 4'd0);
    step(1'b0, 1'b1, 4'd1, 16'h0003, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0);
    chk("full_ready_lit", 32'(last_ready), 32'd0);
    step(1'b0, 1'b1, 4'd1, 16'h0004, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0);
    chk("starve_alu_lit", 32'(rd_data), 32'h0004);
    step(1'b0, 1'b1, 4'd1, 16'h0005, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0);
    chk("starve_stall_lit", 32'(last_stall), 32'd1);
    chk("starve_ld_addr_lit", 32'(rd_addr), 32'd6);
    chk("starve_ld_data_lit", 32'(rd_data), 32'hA006);
    step(1'b0, 1'b1, 4'd1, 16'h0005, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0);
    chk("unstall_lit", 32'(last_stall), 32'd0);
    chk("unstall_data_lit", 32'(rd_data), 32'h0005);
    idle();
    chk("drain_addr_lit", 32'(rd_addr), 32'd9);

    // ALU write to r0
    step(1'b0, 1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0);
    chk("r0_we_lit", 32'(rd_we), 32'd0);
    chk("r0_stall_lit", 32'(last_stall), 32'd0);

    // Scoreboard set / clear / set-wins
    step(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd7);
    chk("busy7_set_lit", 32'(busy[7]), 32'(SB));
    step(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd7, 16'h7777, 1'b0, 4'd0);
    idle();
    chk("busy7_clr_we_lit", 32'(rd_we), 32'd1);
    chk("busy7_clr_lit", 32'(busy[7]), 32'd0);
    step(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd7, 16'h7778, 1'b1, 4'd7);
    step(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd7);
    chk("busy7_setwins_lit", 32'(busy[7]), 32'(SB));
    idle();

    // Reset with loads queued and r4 pending
    step(1'b0, 1'b1, 4'd2, 16'h0010, 1'b1, 4'd4, 16'h4444, 1'b1, 4'd4);
    step(1'b0, 1'b1, 4'd2, 16'h0011, 1'b1, 4'd8, 16'h8888, 1'b0, 4'd0);
    chk("pre_rst_busy4_lit", 32'(busy[4]), 32'(SB));
    step(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0);
    chk("post_rst_we_lit", 32'(rd_we), 32'd0);
    chk("post_rst_busy_lit", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("no_stale_ld_we_lit", 32'(rd_we), 32'd0);
    end

    // Randomized traffic; ALU inputs held while stalled
    h_av = 0; h_aa = 0; h_ad = 0;
    for (int i = 0; i < 3000; i++) begin
      logic r;
      r = ($urandom_range(0, 99) == 0);
      if (!last_stall || r) begin
        h_av = ($urandom_range(0, 99) < 65);
        h_aa = 4'($urandom_range(0, 15));
        h_ad = 16'($urandom);
      end
      step(r, h_av, h_aa, h_ad,
           ($urandom_range(0, 99) < 45), 4'($urandom_range(0, 15)), 16'($urandom),
           ($urandom_range(0, 99) < 30), 4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
